// File: rtl/key_event_decoder.sv
// -----------------------------------------------------------------------------
// key_event_decoder
//
// Purpose:
//   Turns a clean, clock-synchronous key level into single-cycle key events:
//   press, release, short press, long press, auto-repeat while held, and
//   double click. Edge events and the registered key level come straight
//   from a one-register edge detector. The remaining events come from a
//   small gesture FSM with one shared cycle counter.
//
// Parameters:
//   CLK_FREQ   : system clock frequency in Hz
//   LONG_MS    : hold time for a long press in ms (>= 1)
//   DOUBLE_MS  : double-click window after a release in ms (0 = disabled)
//   REPEAT_MS  : auto-repeat period while long-held in ms (0 = disabled)
//   ACTIVE_LOW : 1 = key_in low means pressed
//
// Ports:
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   key_in      in   debounced key level, synchronous to clk
//   key_held    out  registered pressed level
//   press_evt   out  1-cycle pulse on press
//   release_evt out  1-cycle pulse on release
//   short_evt   out  1-cycle pulse, single short press confirmed
//   long_evt    out  1-cycle pulse, long-press threshold reached
//   rpt_evt     out  1-cycle pulse, auto-repeat tick
//   dbl_evt     out  1-cycle pulse, double click
// -----------------------------------------------------------------------------
module key_event_decoder #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int LONG_MS    = 800,
  parameter int DOUBLE_MS  = 250,
  parameter int REPEAT_MS  = 200,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_held,
  output logic press_evt,
  output logic release_evt,
  output logic short_evt,
  output logic long_evt,
  output logic rpt_evt,
  output logic dbl_evt
);

  // Millisecond durations converted to clock cycles.
  localparam int unsigned CYC_PER_MS = CLK_FREQ / 1000;
  localparam logic [31:0] LONG_CYC   = 32'(CYC_PER_MS * LONG_MS);
  localparam logic [31:0] DOUBLE_CYC = 32'(CYC_PER_MS * DOUBLE_MS);
  localparam logic [31:0] REPEAT_CYC = 32'(CYC_PER_MS * REPEAT_MS);

  // Terminal counts. A zero-length window wraps to all ones here, but that
  // value is only ever compared behind the matching enable bit.
  localparam logic [31:0] LONG_LAST   = LONG_CYC - 32'd1;
  localparam logic [31:0] DOUBLE_LAST = DOUBLE_CYC - 32'd1;
  localparam logic [31:0] REPEAT_LAST = REPEAT_CYC - 32'd1;
  localparam bit          DOUBLE_EN   = (DOUBLE_CYC != 32'd0);
  localparam bit          REPEAT_EN   = (REPEAT_CYC != 32'd0);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRESS1 = 3'd1,
    ST_LONG   = 3'd2,
    ST_WAIT2  = 3'd3,
    ST_PRESS2 = 3'd4
  } state_t;

  state_t      r_state;
  logic [31:0] r_cnt;
  logic        r_key_q;
  logic        w_pressed;

  // Normalise polarity so that the rest of the block works in "pressed" terms.
  assign w_pressed = key_in ^ ACTIVE_LOW;

  // Edge detector: previous pressed level, press/release pulses and held level.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_key_q     <= 1'b0;
      key_held    <= 1'b0;
      press_evt   <= 1'b0;
      release_evt <= 1'b0;
    end else begin
      r_key_q     <= w_pressed;
      key_held    <= w_pressed;
      press_evt   <= w_pressed & ~r_key_q;
      release_evt <= ~w_pressed & r_key_q;
    end
  end

  // Gesture FSM. Event outputs default low each cycle. In every state the
  // input-level condition is tested before the counter threshold, so a
  // release on the long-threshold edge takes the short path, and a press on
  // the window-expiry edge still counts as a double click.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 32'd0;
      short_evt <= 1'b0;
      long_evt  <= 1'b0;
      rpt_evt   <= 1'b0;
      dbl_evt   <= 1'b0;
    end else begin
      short_evt <= 1'b0;
      long_evt  <= 1'b0;
      rpt_evt   <= 1'b0;
      dbl_evt   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= 32'd0;
          if (w_pressed) begin
            r_state <= ST_PRESS1;
          end else begin
            r_state <= ST_IDLE;
          end
        end

        ST_PRESS1: begin
          if (!w_pressed) begin
            r_cnt <= 32'd0;
            if (DOUBLE_EN) begin
              r_state <= ST_WAIT2;
            end else begin
              short_evt <= 1'b1;
              r_state   <= ST_IDLE;
            end
          end else if (r_cnt == LONG_LAST) begin
            long_evt <= 1'b1;
            r_cnt    <= 32'd0;
            r_state  <= ST_LONG;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end

        ST_LONG: begin
          if (!w_pressed) begin
            // A long press ends silently; release_evt comes from the edge path.
            r_cnt   <= 32'd0;
            r_state <= ST_IDLE;
          end else if (REPEAT_EN && (r_cnt == REPEAT_LAST)) begin
            rpt_evt <= 1'b1;
            r_cnt   <= 32'd0;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end

        ST_WAIT2: begin
          if (w_pressed) begin
            dbl_evt <= 1'b1;
            r_cnt   <= 32'd0;
            r_state <= ST_PRESS2;
          end else if (r_cnt == DOUBLE_LAST) begin
            short_evt <= 1'b1;
            r_cnt     <= 32'd0;
            r_state   <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end

        ST_PRESS2: begin
          // The second press of a double click has no long/repeat detection,
          // so the counter simply stays at its entry value.
          r_cnt <= 32'd0;
          if (!w_pressed) begin
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_PRESS2;
          end
        end

        default: begin
          r_cnt   <= 32'd0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_event_decoder.sv
// -----------------------------------------------------------------------------
// tb_key_event_decoder
//
// Directed bench for key_event_decoder. Two instances share clock and reset:
// u_dut (ACTIVE_LOW=0) and u_dut_al (ACTIVE_LOW=1). At 1 cycle per ms the
// windows are LONG=50, DOUBLE=10 and REPEAT=20 cycles. Expected events are
// pushed to a scoreboard queue tagged with the edge they belong to. After
// every edge the observed event pattern of both instances is compared with
// the queue head, or with zero when nothing is due. Edge k of a scenario is
// the k-th clock edge after that scenario's base cycle.
// -----------------------------------------------------------------------------
module tb_key_event_decoder;

  localparam logic [15:0] A_P   = 16'h0001;
  localparam logic [15:0] A_R   = 16'h0002;
  localparam logic [15:0] A_S   = 16'h0004;
  localparam logic [15:0] A_L   = 16'h0008;
  localparam logic [15:0] A_RPT = 16'h0010;
  localparam logic [15:0] A_D   = 16'h0020;
  localparam logic [15:0] B_P   = 16'h0100;
  localparam logic [15:0] B_R   = 16'h0200;
  localparam logic [15:0] B_S   = 16'h0400;

  typedef struct {
    int          cyc;
    logic [15:0] mask;
  } sb_entry_t;

  logic clk;
  logic rst;
  logic key_in;
  logic key_in_al;

  logic held_a, press_a, rel_a, short_a, long_a, rpt_a, dbl_a;
  logic held_b, press_b, rel_b, short_b, long_b, rpt_b, dbl_b;

  sb_entry_t sb[$];
  int        cyc;
  int        base;
  int        errors;
  int        checks;
  bit        chk_en;

  key_event_decoder #(
    .CLK_FREQ(1000), .LONG_MS(50), .DOUBLE_MS(10), .REPEAT_MS(20), .ACTIVE_LOW(1'b0)
  ) u_dut (
    .clk(clk), .rst(rst), .key_in(key_in),
    .key_held(held_a), .press_evt(press_a), .release_evt(rel_a),
    .short_evt(short_a), .long_evt(long_a), .rpt_evt(rpt_a), .dbl_evt(dbl_a)
  );

  key_event_decoder #(
    .CLK_FREQ(1000), .LONG_MS(50), .DOUBLE_MS(10), .REPEAT_MS(20), .ACTIVE_LOW(1'b1)
  ) u_dut_al (
    .clk(clk), .rst(rst), .key_in(key_in_al),
    .key_held(held_b), .press_evt(press_b), .release_evt(rel_b),
    .short_evt(short_b), .long_evt(long_b), .rpt_evt(rpt_b), .dbl_evt(dbl_b)
  );

  // Clock generator.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record an expected event pattern for a given edge; patterns on the same edge merge.
  function automatic void push(input int c, input logic [15:0] m);
    if ((sb.size() > 0) && (sb[sb.size()-1].cyc == c)) begin
      sb[sb.size()-1].mask = sb[sb.size()-1].mask | m;
    end else begin
      sb.push_back('{cyc: c, mask: m});
    end
  endfunction

  // One clock edge, then compare both instances against the scoreboard.
  task automatic tick();
    logic        p_rst, p_a, p_b;
    logic [15:0] obs_mask, exp_mask;
    logic [1:0]  obs_held, exp_held;
    sb_entry_t   e;
    p_rst = rst;
    p_a   = key_in;
    p_b   = ~key_in_al;
    @(posedge clk);
    cyc++;
    #1;
    if (chk_en) begin
      exp_mask = 16'h0000;
      if ((sb.size() > 0) && (sb[0].cyc == cyc)) begin
        e        = sb.pop_front();
        exp_mask = e.mask;
      end
      obs_mask = {2'b00, dbl_b, rpt_b, long_b, short_b, rel_b, press_b,
                  2'b00, dbl_a, rpt_a, long_a, short_a, rel_a, press_a};
      checks++;
      assert (obs_mask === exp_mask) else begin
        errors++;
        $error("FAIL events cyc=%0d observed=%h expected=%h", cyc, obs_mask, exp_mask);
      end
      exp_held = {(p_rst ? 1'b0 : p_b), (p_rst ? 1'b0 : p_a)};
      obs_held = {held_b, held_a};
      checks++;
      assert (obs_held === exp_held) else begin
        errors++;
        $error("FAIL key_held cyc=%0d observed=%b expected=%b", cyc, obs_held, exp_held);
      end
    end
  endtask

  // Advance so that the next input change is sampled at scenario edge k.
  task automatic go(input int k);
    while (cyc < base + k - 1) tick();
  endtask

  initial begin
    rst       = 1'b1;
    key_in    = 1'b0;
    key_in_al = 1'b1;
    cyc       = 0;
    base      = 0;
    errors    = 0;
    checks    = 0;
    chk_en    = 1'b0;

    // Reset state: after two edges in reset, all outputs must be 0.
    tick();
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();

    // Short press: press 10, release 30, short confirmed when the window closes at 40.
    base = cyc;
    push(base + 10, A_P);
    push(base + 30, A_R);
    push(base + 40, A_S);
    go(10); key_in = 1'b1;
    go(30); key_in = 1'b0;
    go(60);

    // Long press with auto-repeat: press 10, hold until release at 120.
    base = cyc;
    push(base + 10,  A_P);
    push(base + 60,  A_L);
    push(base + 80,  A_RPT);
    push(base + 100, A_RPT);
    push(base + 120, A_R);
    go(10);  key_in = 1'b1;
    go(120); key_in = 1'b0;
    go(150);

    // Release on the long-threshold edge takes the short path.
    base = cyc;
    push(base + 10, A_P);
    push(base + 60, A_R);
    push(base + 70, A_S);
    go(10); key_in = 1'b1;
    go(60); key_in = 1'b0;
    go(90);

    // Double click: second press on the last edge of the window.
    base = cyc;
    push(base + 10, A_P);
    push(base + 20, A_R);
    push(base + 30, A_P | A_D);
    push(base + 40, A_R);
    go(10); key_in = 1'b1;
    go(20); key_in = 1'b0;
    go(30); key_in = 1'b1;
    go(40); key_in = 1'b0;
    go(70);

    // Second press one edge late: short at 30, then a fresh press from 31.
    base = cyc;
    push(base + 10, A_P);
    push(base + 20, A_R);
    push(base + 30, A_S);
    push(base + 31, A_P);
    push(base + 41, A_R);
    push(base + 51, A_S);
    go(10); key_in = 1'b1;
    go(20); key_in = 1'b0;
    go(31); key_in = 1'b1;
    go(41); key_in = 1'b0;
    go(80);

    // Active-low instance: key_in_al low from edge 5, back high at edge 15.
    base = cyc;
    push(base + 5,  B_P);
    push(base + 15, B_R);
    push(base + 25, B_S);
    go(5);  key_in_al = 1'b0;
    go(15); key_in_al = 1'b1;
    go(50);

    // Reset during a long hold: rst sampled at 41 and 42 with the key still pressed.
    base = cyc;
    push(base + 10,  A_P);
    push(base + 43,  A_P);
    push(base + 93,  A_L);
    push(base + 100, A_R);
    go(10);  key_in = 1'b1;
    go(41);  rst = 1'b1;
    go(43);  rst = 1'b0;
    go(100); key_in = 1'b0;
    go(130);

    // Every expected event must have been consumed.
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
